// File: rtl/ddr_axi_port_arbiter.sv
// Three-requester round-robin arbiter in front of one DDR controller user port.
// Independent write/read address arbitration, write data locked to its owner, in-order read return routing.
module ddr_axi_port_arbiter #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH      = 256,
    parameter int RD_OUTSTANDING  = 8
) (
    input  logic                           core_clk,
    input  logic                           core_rst,

    input  logic [2:0]                     m_awvalid,
    output logic [2:0]                     m_awready,
    input  logic [3*CTRL_ADDR_WIDTH-1:0]   m_awaddr,
    input  logic [3*4-1:0]                 m_awlen,
    input  logic [3*4-1:0]                 m_awuser_id,
    input  logic [2:0]                     m_awuser_ap,
    input  logic [3*DATA_WIDTH-1:0]        m_wdata,
    input  logic [3*DATA_WIDTH/8-1:0]      m_wstrb,
    output logic [2:0]                     m_wready,
    output logic [2:0]                     m_wusero_last,
    output logic [3:0]                     m_wusero_id,
    input  logic [2:0]                     m_arvalid,
    output logic [2:0]                     m_arready,
    input  logic [3*CTRL_ADDR_WIDTH-1:0]   m_araddr,
    input  logic [3*4-1:0]                 m_arlen,
    input  logic [3*4-1:0]                 m_aruser_id,
    input  logic [2:0]                     m_aruser_ap,
    output logic [2:0]                     m_rvalid,
    output logic [DATA_WIDTH-1:0]          m_rdata,
    output logic [3:0]                     m_rid,
    output logic                           m_rlast,

    output logic                           s_awvalid,
    input  logic                           s_awready,
    output logic [CTRL_ADDR_WIDTH-1:0]     s_awaddr,
    output logic [3:0]                     s_awlen,
    output logic [3:0]                     s_awuser_id,
    output logic                           s_awuser_ap,
    output logic [DATA_WIDTH-1:0]          s_wdata,
    output logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wready,
    input  logic                           s_wusero_last,
    input  logic [3:0]                     s_wusero_id,
    output logic                           s_arvalid,
    input  logic                           s_arready,
    output logic [CTRL_ADDR_WIDTH-1:0]     s_araddr,
    output logic [3:0]                     s_arlen,
    output logic [3:0]                     s_aruser_id,
    output logic                           s_aruser_ap,
    input  logic                           s_rvalid,
    input  logic [DATA_WIDTH-1:0]          s_rdata,
    input  logic [3:0]                     s_rid,
    input  logic                           s_rlast,

    output logic                           rd_orphan_err
);

    localparam int AW = CTRL_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = $clog2(RD_OUTSTANDING);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_t;
    typedef enum logic       {R_IDLE, R_ADDR}         r_state_t;

    // First requesting index found when scanning upward from ptr, wrapping modulo 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] pick;
        logic       found;
        logic [2:0] idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!found && req[idx[1:0]]) begin
                pick  = idx[1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    w_state_t       w_state, w_next;
    logic [1:0]     wg, wg_next, wptr, wptr_next;
    r_state_t       r_state, r_next;
    logic [1:0]     rg, rg_next, rptr, rptr_next;

    logic [1:0]     route_mem [RD_OUTSTANDING];
    logic [PW-1:0]  fifo_wr_ptr, fifo_rd_ptr;
    logic [CW-1:0]  fifo_count;
    logic           fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [1:0]     route_head;

    // ---------------- write path ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            w_state <= W_IDLE;
            wg      <= 2'd0;
            wptr    <= 2'd0;
        end else begin
            w_state <= w_next;
            wg      <= wg_next;
            wptr    <= wptr_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next        = w_state;
        wg_next       = wg;
        wptr_next     = wptr;
        s_awvalid     = 1'b0;
        m_awready     = 3'b000;
        m_wready      = 3'b000;
        m_wusero_last = 3'b000;
        case (w_state)
            W_IDLE: begin
                if (|m_awvalid) begin
                    wg_next = rr_pick(m_awvalid, wptr);
                    w_next  = W_ADDR;
                end
            end
            W_ADDR: begin
                s_awvalid         = 1'b1;
                m_awready[wg]     = s_awready;
                m_wready[wg]      = s_wready;
                m_wusero_last[wg] = s_wusero_last;
                if (s_awready) begin
                    w_next    = W_DATA;
                    wptr_next = inc3(wg);
                end
            end
            W_DATA: begin
                m_wready[wg]      = s_wready;
                m_wusero_last[wg] = s_wusero_last;
                if (s_wready && s_wusero_last) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign s_awaddr    = m_awaddr[AW*wg +: AW];
    assign s_awlen     = m_awlen[4*wg +: 4];
    assign s_awuser_id = m_awuser_id[4*wg +: 4];
    assign s_awuser_ap = m_awuser_ap[wg];
    assign s_wdata     = m_wdata[DW*wg +: DW];
    assign s_wstrb     = m_wstrb[SW*wg +: SW];
    assign m_wusero_id = s_wusero_id;

    // ---------------- read address path ----------------
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_state <= R_IDLE;
            rg      <= 2'd0;
            rptr    <= 2'd0;
        end else begin
            r_state <= r_next;
            rg      <= rg_next;
            rptr    <= rptr_next;
        end
    end

    always_comb begin
        r_next    = r_state;
        rg_next   = rg;
        rptr_next = rptr;
        s_arvalid = 1'b0;
        m_arready = 3'b000;
        fifo_push = 1'b0;
        case (r_state)
            R_IDLE: begin
                // Holding off the grant while full keeps every accepted AR routable.
                if ((|m_arvalid) && !fifo_full) begin
                    rg_next = rr_pick(m_arvalid, rptr);
                    r_next  = R_ADDR;
                end
            end
            R_ADDR: begin
                s_arvalid     = 1'b1;
                m_arready[rg] = s_arready;
                if (s_arready) begin
                    fifo_push = 1'b1;
                    rptr_next = inc3(rg);
                    r_next    = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign s_araddr    = m_araddr[AW*rg +: AW];
    assign s_arlen     = m_arlen[4*rg +: 4];
    assign s_aruser_id = m_aruser_id[4*rg +: 4];
    assign s_aruser_ap = m_aruser_ap[rg];

    // ---------------- read return routing ----------------
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(RD_OUTSTANDING));
    assign fifo_pop   = s_rvalid && s_rlast && !fifo_empty;
    assign route_head = route_mem[fifo_rd_ptr];

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            fifo_wr_ptr   <= '0;
            fifo_rd_ptr   <= '0;
            fifo_count    <= '0;
            rd_orphan_err <= 1'b0;
        end else begin
            if (fifo_push) fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
            if (fifo_pop)  fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (s_rvalid && fifo_empty) rd_orphan_err <= 1'b1;
        end
    end

    // NOTE: storage is left unreset; the count gates every read, so stale entries are never observed.
    always_ff @(posedge core_clk) begin
        if (fifo_push) route_mem[fifo_wr_ptr] <= rg;
    end

    always_comb begin
        m_rvalid = 3'b000;
        if (!fifo_empty) m_rvalid[route_head] = s_rvalid;
    end

    assign m_rdata = s_rdata;
    assign m_rid   = s_rid;
    assign m_rlast = s_rlast;

endmodule

// File: tb/tb_ddr_axi_port_arbiter.sv
// Scoreboard bench for ddr_axi_port_arbiter: expectations queued at stimulus time,
// popped and compared at the negedge on each controller-side handshake or beat.
module tb_ddr_axi_port_arbiter;

    localparam int AW    = 28;
    localparam int DW    = 256;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 8;

    logic              core_clk = 1'b0;
    logic              core_rst;
    logic [2:0]        m_awvalid, m_awready, m_awuser_ap, m_wready, m_wusero_last;
    logic [3*AW-1:0]   m_awaddr, m_araddr;
    logic [11:0]       m_awlen, m_awuser_id, m_arlen, m_aruser_id;
    logic [3*DW-1:0]   m_wdata;
    logic [3*SW-1:0]   m_wstrb;
    logic [3:0]        m_wusero_id, m_rid, s_awlen, s_awuser_id, s_wusero_id, s_arlen, s_aruser_id, s_rid;
    logic [2:0]        m_arvalid, m_arready, m_aruser_ap, m_rvalid;
    logic [DW-1:0]     m_rdata, s_wdata, s_rdata;
    logic              m_rlast, s_awvalid, s_awready, s_awuser_ap, s_wready, s_wusero_last;
    logic [AW-1:0]     s_awaddr, s_araddr;
    logic [SW-1:0]     s_wstrb;
    logic              s_arvalid, s_arready, s_aruser_ap, s_rvalid, s_rlast, rd_orphan_err;

    ddr_axi_port_arbiter #(.CTRL_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_OUTSTANDING(DEPTH)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awuser_id(m_awuser_id), .m_awuser_ap(m_awuser_ap), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wready(m_wready), .m_wusero_last(m_wusero_last), .m_wusero_id(m_wusero_id),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_aruser_id(m_aruser_id), .m_aruser_ap(m_aruser_ap), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .m_rid(m_rid), .m_rlast(m_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awuser_id(s_awuser_id), .s_awuser_ap(s_awuser_ap), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wready(s_wready), .s_wusero_last(s_wusero_last), .s_wusero_id(s_wusero_id),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_aruser_id(s_aruser_id), .s_aruser_ap(s_aruser_ap), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .s_rid(s_rid), .s_rlast(s_rlast), .rd_orphan_err(rd_orphan_err)
    );

    always #5 core_clk = ~core_clk;

    int cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]   mask;
        logic [2:0]   lmask;
        logic [255:0] val;
    } exp_t;

    exp_t aw_q[$], w_q[$], ar_q[$], r_q[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] wpat(input int r, input int b);
        logic [31:0] w;
        w = 32'hC0DE0000 | 32'(r * 256 + b);
        return {8{w}};
    endfunction

    function automatic logic [255:0] rpat(input int n);
        logic [31:0] w;
        w = 32'h5EAD0000 | 32'(n);
        return {8{w}};
    endfunction

    function automatic logic [255:0] ar_val(input int r);
        logic [AW-1:0] a;
        logic [3:0]    id;
        a  = 28'h0B00000 + 28'(r * 16);
        id = 4'(8 + r);
        return 256'({r[0], id, 4'd1, a});
    endfunction

    // Scoreboard monitor: compares controller-side events against queued expectations.
    always @(negedge core_clk) begin
        exp_t e;
        if (!core_rst) begin
            if (s_awvalid && s_awready) begin
                if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
                else begin
                    e = aw_q.pop_front();
                    check("aw_fields", 256'({s_awuser_ap, s_awuser_id, s_awlen, s_awaddr}), e.val);
                    check("aw_ready", 256'(m_awready), 256'(e.mask));
                end
            end
            if (s_wready) begin
                if (w_q.size() == 0) check("w_unexpected", 1, 0);
                else begin
                    e = w_q.pop_front();
                    check("w_data", s_wdata, e.val);
                    check("w_ready", 256'(m_wready), 256'(e.mask));
                    check("w_last", 256'(m_wusero_last), 256'(e.lmask));
                end
            end
            if (s_arvalid && s_arready) begin
                if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
                else begin
                    e = ar_q.pop_front();
                    check("ar_fields", 256'({s_aruser_ap, s_aruser_id, s_arlen, s_araddr}), e.val);
                    check("ar_ready", 256'(m_arready), 256'(e.mask));
                end
            end
            if (s_rvalid) begin
                if (r_q.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    e = r_q.pop_front();
                    check("r_valid", 256'(m_rvalid), 256'(e.mask));
                    check("r_data", m_rdata, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    // Write from requester r; rst_beat >= 0 asserts core_rst during that data beat instead.
    task automatic do_write(input int r, input logic [AW-1:0] addr, input logic [3:0] len,
                            input logic [3:0] id, input int rst_beat);
        exp_t e;
        bit   ok;
        m_awaddr[r*AW +: AW]  = addr;
        m_awlen[r*4 +: 4]     = len;
        m_awuser_id[r*4 +: 4] = id;
        m_awuser_ap[r]        = 1'b1;
        m_awvalid[r]          = 1'b1;
        e.mask  = 3'b001 << r;
        e.lmask = 3'b000;
        e.val   = 256'({1'b1, id, len, addr});
        aw_q.push_back(e);
        s_awready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge core_clk);
            if (m_awready[r]) ok = 1'b1;
        end
        check("aw_timeout", 256'(ok), 256'(1));
        tick();
        m_awvalid[r] = 1'b0;
        s_awready    = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            for (int k = 0; k < 3; k++) m_wdata[k*DW +: DW] = wpat(k, b);
            if (b == rst_beat) begin
                s_wready = 1'b1;
                core_rst = 1'b1;
                tick();
                core_rst = 1'b0;
                s_wready = 1'b0;
                return;
            end
            s_wready      = 1'b1;
            s_wusero_last = (b == int'(len));
            e.mask  = 3'b001 << r;
            e.lmask = (b == int'(len)) ? e.mask : 3'b000;
            e.val   = wpat(r, b);
            w_q.push_back(e);
            tick();
            s_wready      = 1'b0;
            s_wusero_last = 1'b0;
            if (b % 2 == 0) tick();
        end
    endtask

    task automatic push_ar(input int r);
        exp_t e;
        e.mask  = 3'b001 << r;
        e.lmask = 3'b000;
        e.val   = ar_val(r);
        ar_q.push_back(e);
    endtask

    // Count n AR handshakes (bounded), leaving the clock just past the last handshake edge.
    task automatic wait_ar(input int n, input string tag);
        int got;
        got = 0;
        for (int k = 0; k < 40 * n && got < n; k++) begin
            @(negedge core_clk);
            if (s_arvalid && s_arready) got++;
        end
        check(tag, 256'(got), 256'(n));
        tick();
    endtask

    task automatic ar_one(input int r);
        push_ar(r);
        m_arvalid[r] = 1'b1;
        s_arready    = 1'b1;
        wait_ar(1, "ar_one_timeout");
        m_arvalid[r] = 1'b0;
    endtask

    task automatic rbeat(input logic [2:0] mask, input bit last, input int n);
        exp_t e;
        s_rvalid = 1'b1;
        s_rlast  = last;
        s_rdata  = rpat(n);
        s_rid    = 4'(n);
        e.mask   = mask;
        e.lmask  = 3'b000;
        e.val    = rpat(n);
        r_q.push_back(e);
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [2:0] rr_masks [7];
        int nsv, p, hs;
        bit found;

        core_rst = 1'b1;
        m_awvalid = '0; m_awuser_ap = '0; m_awlen = '0; m_awuser_id = '0;
        m_wdata = '0; m_wstrb = '1; m_arvalid = '0;
        s_awready = 0; s_wready = 0; s_wusero_last = 0; s_wusero_id = 4'h3;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rid = '0; s_rlast = 0;
        for (int k = 0; k < 3; k++) begin
            m_awaddr[k*AW +: AW]  = 28'h00000A0 + 28'(k);
            m_araddr[k*AW +: AW]  = 28'h0B00000 + 28'(k * 16);
            m_arlen[k*4 +: 4]     = 4'd1;
            m_aruser_id[k*4 +: 4] = 4'(8 + k);
            m_aruser_ap[k]        = k[0];
        end

        // Reset state
        tick(); tick();
        @(negedge core_clk);
        check("rst_ctrl", 256'({s_awvalid, m_awready, m_wready, m_wusero_last, s_arvalid,
                                m_arready, m_rvalid, rd_orphan_err}), 256'(0));
        check("rst_awaddr_mux", 256'(s_awaddr), 256'(28'h00000A0));
        check("rst_araddr_mux", 256'(s_araddr), 256'(28'h0B00000));
        tick();
        core_rst = 1'b0;
        tick();

        // Single write from requester 1
        do_write(1, 28'h0000100, 4'd3, 4'd5, -1);
        @(negedge core_clk);
        check("w1_idle_awvalid", 256'(s_awvalid), 256'(0));
        tick();

        // Round-robin: six grants with all requesters asserted, then one more shows rptr back at 0
        for (int g = 0; g < 6; g++) push_ar(g % 3);
        m_arvalid = 3'b111;
        s_arready = 1'b1;
        wait_ar(6, "rr_grants");
        m_arvalid = 3'b000;
        push_ar(0);
        m_arvalid = 3'b111;
        wait_ar(1, "rr_rptr_zero");
        m_arvalid = 3'b000;
        rr_masks = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        for (int k = 0; k < 7; k++) rbeat(rr_masks[k], 1'b1, k);
        tick();

        // Route FIFO full: 8 ARs accepted, the 9th waits for the first rlast
        for (int g = 0; g < DEPTH; g++) push_ar(0);
        m_arvalid[0] = 1'b1;
        wait_ar(DEPTH, "full_fill");
        nsv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge core_clk);
            if (s_arvalid) nsv++;
        end
        check("full_stall", 256'(nsv), 256'(0));
        tick();
        push_ar(0);
        rbeat(3'b001, 1'b1, 20);
        p = cyc;
        found = 1'b0;
        hs = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge core_clk);
            if (s_arvalid && s_arready) begin
                found = 1'b1;
                hs = cyc + 1;
            end
        end
        check("full_regrant", 256'(found), 256'(1));
        check("full_regrant_gap", 256'((hs - p) >= 2), 256'(1));
        tick();
        m_arvalid[0] = 1'b0;
        for (int k = 0; k < DEPTH; k++) rbeat(3'b001, 1'b1, 30 + k);
        tick();

        // In-order return: requester 2 then 0, two beats each
        ar_one(2);
        ar_one(0);
        s_arready = 1'b0;
        rbeat(3'b100, 1'b0, 40);
        rbeat(3'b100, 1'b1, 41);
        tick();
        rbeat(3'b001, 1'b0, 42);
        rbeat(3'b001, 1'b1, 43);

        // Orphan beat on an empty FIFO
        @(negedge core_clk);
        check("orphan_before", 256'(rd_orphan_err), 256'(0));
        tick();
        rbeat(3'b000, 1'b1, 50);
        for (int k = 0; k < 4; k++) begin
            @(negedge core_clk);
            check("orphan_sticky", 256'(rd_orphan_err), 256'(1));
        end
        tick();

        // Reset during beat 2 of 4 of an m0 write, then m0 and m1 contend
        do_write(0, 28'h0000200, 4'd3, 4'd1, 1);
        @(negedge core_clk);
        check("rst_mid_ctrl", 256'({s_awvalid, m_awready, m_wready, m_wusero_last, s_arvalid,
                                    m_arready, m_rvalid, rd_orphan_err}), 256'(0));
        tick();
        m_awaddr[1*AW +: AW]  = 28'h0000300;
        m_awlen[1*4 +: 4]     = 4'd1;
        m_awuser_id[1*4 +: 4] = 4'd7;
        m_awuser_ap[1]        = 1'b1;
        m_awvalid[1]          = 1'b1;
        do_write(0, 28'h0000400, 4'd1, 4'd2, -1);
        do_write(1, 28'h0000300, 4'd1, 4'd7, -1);
        tick(); tick();

        check("queues_drained", 256'(aw_q.size() + w_q.size() + ar_q.size() + r_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
